jmb_scanline_output_packer: RTL
===============================

JMB_SCANLINE_OUTPUT_PACKER -- requirements
Module: jmb_scanline_output_packer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; all sequential logic is clocked on the rising edge of clock.
REQ-002 Ports SHALL be exactly as listed below.
  clock  in  1  rising-edge system clock
  reset  in  1  asynchronous, active-high reset
  pixel_in  in  8  pixel from the scanline filter control (pixel_out)
  pixel_wr  in  1  pixel_in valid this cycle
  pixel_filter  in  1  pixel was produced by the filter (0 = border/passthrough)
  width  in  32  frame width in pixels; sampled on start
  height  in  32  frame height in lines; sampled on start
  base_addr  in  32  byte address of pixel (0,0); sampled on start; bits [1:0] ignored
  start  in  1  one-cycle pulse that begins a frame
  mem_ready  in  1  memory accepts the presented word this cycle
  mem_wr  out  1  word write request
  mem_addr  out  32  word-aligned byte address
  mem_data  out  32  packed pixels, lane k = bits [8k+7:8k]
  mem_be  out  4  byte enables
  stall  out  1  upstream SHALL NOT assert pixel_wr while this is high
  busy  out  1  frame in progress
  frame_done  out  1  one-cycle pulse at frame end
  overrun  out  1  sticky: a pixel arrived while stall was high

Function
REQ-003 SHALL implement the states IDLE, RUN, FLUSH and DONE.
REQ-004 IDLE->RUN on start when width!=0 and height!=0; width, height and base_addr latched; x=0, y=0, lane=0.
REQ-005 start with width==0 or height==0 SHALL go IDLE->DONE with no memory writes.
REQ-006 start while not in IDLE SHALL be ignored.
REQ-007 Each accepted pixel (pixel_wr=1 and stall=0) SHALL be stored in lane x[1:0] of the pack register; x SHALL increment.
REQ-008 A word SHALL complete when lane 3 is written or when x==width-1 (end-of-line flush); mem_be SHALL set only the written lanes, and unwritten lanes of mem_data SHALL be 0.
REQ-009 A completed word SHALL move to the output register; mem_wr SHALL rise on the cycle after the completing pixel is accepted (1-cycle latency).
REQ-010 mem_wr, mem_addr, mem_data and mem_be SHALL hold stable until the first cycle with mem_ready=1; mem_wr SHALL drop on the next cycle unless a new word is loaded at the same time.
REQ-011 stall SHALL equal mem_wr & ~mem_ready & (the next pixel would complete a word), computed combinationally.
REQ-012 Addressing: stride = (width+3) & ~3; word address = base + y*stride + 4*(x>>2); SHALL be computed incrementally with no multiplier.
REQ-013 At end of line x SHALL wrap to 0 and y SHALL increment; after the last pixel of line height-1 the block SHALL enter FLUSH.
REQ-014 FLUSH->DONE SHALL occur once the final word is accepted; DONE SHALL pulse frame_done for one cycle and then go to IDLE.
REQ-015 pixel_wr in IDLE or DONE SHALL be ignored; pixel_wr while stall=1 SHALL be dropped and SHALL set overrun, which is cleared only by reset or start.
REQ-016 busy SHALL be 1 in RUN and FLUSH.
REQ-017 All address arithmetic SHALL be 32-bit modulo 2^32.

Reset
REQ-018 Reset SHALL force IDLE and drive mem_wr=0, mem_addr=0, mem_data=0, mem_be=0, busy=0, frame_done=0 and overrun=0; stall SHALL then be 0.
REQ-019 Reset mid-frame SHALL discard any partial or pending word; no mem_wr SHALL be issued after reset deasserts until a new start.

Configuration
REQ-020 With JMB_OUTPACK_BORDER_ZERO_EN defined, a pixel with pixel_filter=0 SHALL be stored as 8'h00 (its byte enable is still set); without the macro, pixel_in SHALL be stored unchanged regardless of pixel_filter.

Structure
REQ-021 The shared package jmb_scanline_pkg SHALL hold the state encoding constants (IDLE, RUN, FLUSH, DONE), the lane count (4) and the pixel width (8).
REQ-022 Address generation SHALL be the sub-module jmb_scanline_addr_gen, with inputs start/base/stride/advance_word/advance_line and output addr.

Verification
REQ-023 width=8, height=2, base=0x1000, 16 back-to-back pixels 0x00..0x0F, mem_ready=1 -> words 0x03020100@0x1000, 0x07060504@0x1004, 0x0B0A0908@0x1008, 0x0F0E0D0C@0x100C, all mem_be=4'hF, then frame_done.
REQ-024 width=5, height=2, base=0x2000 -> partial words with mem_be=4'h1 @0x2004 and @0x200C; line 2 starts @0x2008.
REQ-025 mem_ready held 0 for 6 cycles, continuous pixels -> stall=1 before the next completing pixel; mem_wr/addr/data stable; overrun stays 0.
REQ-026 Pixel driven while stall=1 -> pixel dropped and overrun=1 until the next start.
REQ-027 Reset asserted mid-line -> outputs reach reset values asynchronously; a new start at width=4, height=1 produces exactly one write.
REQ-028 With JMB_OUTPACK_BORDER_ZERO_EN, pixel_filter=0 on lanes 0 and 3 of 0xAABBCCDD -> mem_data=0x00BBCC00, mem_be=4'hF.

Source files
------------

// File: rtl/jmb_scanline_pkg.sv
// Shared definitions for the scanline output packer: FSM encoding, lane geometry
// and the line-stride helper.
package jmb_scanline_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned LANES  = 4;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned WORD_W = LANES * PIX_W;

    // Line pitch in bytes: width rounded up to a whole word.
    function automatic logic [31:0] line_stride(input logic [31:0] w);
        return (w + 32'd3) & ~32'd3;
    endfunction

endpackage

// File: rtl/jmb_scanline_addr_gen.sv
// Incremental word-address generator: tracks the current line base and the
// current word address, so no multiplier is needed for y*stride.
module jmb_scanline_addr_gen (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base,
    input  logic [31:0] stride,
    input  logic        advance_word,
    input  logic        advance_line,
    output logic [31:0] addr
);

    logic [31:0] line_base_q;
    logic [31:0] addr_q;
    logic [31:0] next_line;

    assign next_line = line_base_q + stride;
    assign addr      = addr_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            line_base_q <= 32'd0;
            addr_q      <= 32'd0;
        end else if (start) begin
            line_base_q <= {base[31:2], 2'b00};
            addr_q      <= {base[31:2], 2'b00};
        end else if (advance_line) begin
            line_base_q <= next_line;
            addr_q      <= next_line;
        end else if (advance_word) begin
            addr_q      <= addr_q + 32'd4;
        end
    end

endmodule

// File: rtl/jmb_scanline_output_packer.sv
// Packs 8-bit scanline pixels into 32-bit memory words with byte enables.
// Optional macro JMB_OUTPACK_BORDER_ZERO_EN stores non-filtered pixels as zero.
module jmb_scanline_output_packer
    import jmb_scanline_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  pixel_in,
    input  logic        pixel_wr,
    input  logic        pixel_filter,
    input  logic [31:0] width,
    input  logic [31:0] height,
    input  logic [31:0] base_addr,
    input  logic        start,
    input  logic        mem_ready,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic [3:0]  mem_be,
    output logic        stall,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    state_t              state_q, state_d;
    logic [31:0]         width_q, height_q;
    logic [31:0]         x_q, y_q;
    logic [WORD_W-1:0]   pack_data_q;
    logic [LANES-1:0]    pack_be_q;
    logic [WORD_W-1:0]   merged_data;
    logic [LANES-1:0]    merged_be;
    logic [PIX_W-1:0]    pixel_val;
    logic [1:0]          lane;
    logic                last_x, last_y, would_complete;
    logic                accept, complete, start_ok, dims_ok;
    logic [31:0]         cur_addr;

    assign lane           = x_q[1:0];
    assign last_x         = (x_q == width_q - 32'd1);
    assign last_y         = (y_q == height_q - 32'd1);
    assign would_complete = (lane == 2'd3) | last_x;
    assign stall          = mem_wr & ~mem_ready & would_complete;
    assign accept         = pixel_wr & ~stall & (state_q == RUN);
    assign complete       = accept & would_complete;
    assign start_ok       = start & (state_q == IDLE);
    assign dims_ok        = (width != 32'd0) && (height != 32'd0);
    assign busy           = (state_q == RUN) || (state_q == FLUSH);
    assign frame_done     = (state_q == DONE);

`ifdef JMB_OUTPACK_BORDER_ZERO_EN
    assign pixel_val = pixel_filter ? pixel_in : 8'h00;
`else
    assign pixel_val = pixel_in;
    logic unused_filter;
    assign unused_filter = pixel_filter;
`endif

    always_comb begin
        merged_data = pack_data_q;
        merged_be   = pack_be_q;
        for (int k = 0; k < LANES; k++) begin
            if (lane == 2'(k)) begin
                merged_data[k*PIX_W +: PIX_W] = pixel_val;
                merged_be[k]                  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = dims_ok ? RUN : DONE;
            RUN:     if (accept && last_x && last_y) state_d = FLUSH;
            FLUSH:   if (!mem_wr || mem_ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            width_q     <= 32'd0;
            height_q    <= 32'd0;
            x_q         <= 32'd0;
            y_q         <= 32'd0;
            pack_data_q <= '0;
            pack_be_q   <= '0;
            overrun     <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_data    <= 32'd0;
            mem_be      <= 4'd0;
        end else begin
            state_q <= state_d;

            if (start_ok) begin
                width_q     <= width;
                height_q    <= height;
                x_q         <= 32'd0;
                y_q         <= 32'd0;
                pack_data_q <= '0;
                pack_be_q   <= '0;
            end else if (accept) begin
                if (last_x) begin
                    x_q <= 32'd0;
                    y_q <= y_q + 32'd1;
                end else begin
                    x_q <= x_q + 32'd1;
                end
                pack_data_q <= complete ? '0 : merged_data;
                pack_be_q   <= complete ? '0 : merged_be;
            end

            if (start_ok) begin
                overrun <= 1'b0;
            end else if (pixel_wr && stall) begin
                overrun <= 1'b1;
            end

            // Stall guarantees the output slot is free or draining when a word completes.
            if (complete) begin
                mem_wr   <= 1'b1;
                mem_addr <= cur_addr;
                mem_data <= merged_data;
                mem_be   <= merged_be;
            end else if (mem_ready) begin
                mem_wr   <= 1'b0;
            end
        end
    end

    jmb_scanline_addr_gen u_addr_gen (
        .clock        (clock),
        .reset        (reset),
        .start        (start_ok),
        .base         (base_addr),
        .stride       (line_stride(width_q)),
        .advance_word (complete & ~last_x),
        .advance_line (complete & last_x),
        .addr         (cur_addr)
    );

endmodule
